// File: rtl/temp_to_adc_if.sv
// Request/result bundle between the host configuration side and the
// temperature-to-ADC-code converter.
interface temp_to_adc_if;
    logic [15:0] i_temp_value;
    logic        i_temp_start;
    logic        o_busy;
    logic        o_adc_done;
    logic [11:0] o_adc_value;

    modport master (
        output i_temp_value,
        output i_temp_start,
        input  o_busy,
        input  o_adc_done,
        input  o_adc_value
    );

    modport slave (
        input  i_temp_value,
        input  i_temp_start,
        output o_busy,
        output o_adc_done,
        output o_adc_value
    );
endinterface

// File: rtl/temp_to_adc.sv
// Converts an unsigned 8.8 fixed-point temperature (degC x 256) into the
// NTC thermistor ADC code expected at that temperature, by piecewise-linear
// interpolation over a 22-point calibration table (0..105 degC, 5 degC steps).
// The segment is found by repeated subtraction, the slope term is formed by
// an 11-cycle shift-add multiply, and the division by the segment width is a
// 20-cycle restoring divide, so the datapath needs no hardware multiplier.
module temp_to_adc (
    input  logic         i_clk_50m,
    input  logic         i_rst,
    temp_to_adc_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_JUDGE,
        S_SEARCH,
        S_MULT,
        S_DIV,
        S_OUT,
        S_DONE
    } state_t;

    // One table segment is 5 degC in 8.8 format.
    localparam logic [15:0] SEG_W      = 16'd1280;
    // 105 degC and above saturates to the last table entry.
    localparam logic [15:0] CLAMP_T    = 16'd26880;
    localparam logic [11:0] CLAMP_CODE = 12'd138;
    localparam logic [11:0] DIVISOR    = 12'd1280;
    localparam logic [4:0]  MULT_LAST  = 5'd10;
    localparam logic [4:0]  DIV_LAST   = 5'd19;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] rem;
    logic [4:0]  idx;
    logic [4:0]  cnt;
    logic [10:0] mplier;
    logic [19:0] mcand;
    logic [19:0] prod;
    logic [11:0] prem;
    logic [11:0] seg_drop;
    logic [11:0] div_trial;

    // NTC calibration table: entry k is the ADC code at 5*k degC.
    function automatic logic [11:0] ntc_code(input logic [4:0] k);
        case (k)
            5'd0:    ntc_code = 12'd2853;
            5'd1:    ntc_code = 12'd2558;
            5'd2:    ntc_code = 12'd2271;
            5'd3:    ntc_code = 12'd1997;
            5'd4:    ntc_code = 12'd1742;
            5'd5:    ntc_code = 12'd1510;
            5'd6:    ntc_code = 12'd1302;
            5'd7:    ntc_code = 12'd1118;
            5'd8:    ntc_code = 12'd958;
            5'd9:    ntc_code = 12'd820;
            5'd10:   ntc_code = 12'd701;
            5'd11:   ntc_code = 12'd599;
            5'd12:   ntc_code = 12'd513;
            5'd13:   ntc_code = 12'd439;
            5'd14:   ntc_code = 12'd377;
            5'd15:   ntc_code = 12'd325;
            5'd16:   ntc_code = 12'd280;
            5'd17:   ntc_code = 12'd242;
            5'd18:   ntc_code = 12'd209;
            5'd19:   ntc_code = 12'd181;
            5'd20:   ntc_code = 12'd159;
            default: ntc_code = 12'd138;
        endcase
    endfunction

    // Code drop across the current segment (table is monotonically falling).
    assign seg_drop  = ntc_code(idx) - ntc_code(idx + 5'd1);
    // Partial remainder shifted left with the next dividend bit brought in.
    assign div_trial = (prem << 1) | {11'd0, prod[19]};

    // State register.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt      = state;
        bus.o_busy     = 1'b1;
        bus.o_adc_done = 1'b0;
        case (state)
            S_IDLE: begin
                bus.o_busy = 1'b0;
                if (bus.i_temp_start) begin
                    state_nxt = S_JUDGE;
                end
            end
            S_JUDGE: begin
                state_nxt = (rem >= CLAMP_T) ? S_DONE : S_SEARCH;
            end
            S_SEARCH: begin
                if (rem < SEG_W) begin
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                if (cnt == MULT_LAST) begin
                    state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (cnt == DIV_LAST) begin
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.o_adc_done = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: segment search, shift-add multiply, restoring divide, result.
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            rem             <= '0;
            idx             <= '0;
            cnt             <= '0;
            mplier          <= '0;
            mcand           <= '0;
            prod            <= '0;
            prem            <= '0;
            bus.o_adc_value <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_temp_start) begin
                        rem <= bus.i_temp_value;
                        idx <= '0;
                    end
                end
                S_JUDGE: begin
                    // The result register is loaded on the edge entering DONE.
                    if (rem >= CLAMP_T) begin
                        bus.o_adc_value <= CLAMP_CODE;
                    end
                end
                S_SEARCH: begin
                    if (rem >= SEG_W) begin
                        rem <= rem - SEG_W;
                        idx <= idx + 5'd1;
                    end else begin
                        mcand  <= {8'd0, seg_drop};
                        mplier <= rem[10:0];
                        prod   <= '0;
                        cnt    <= '0;
                    end
                end
                S_MULT: begin
                    if (mplier[0]) begin
                        prod <= prod + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == MULT_LAST) begin
                        cnt  <= '0;
                        prem <= '0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                S_DIV: begin
                    // prod shifts out dividend bits and shifts in quotient bits.
                    prod <= {prod[18:0], (div_trial >= DIVISOR)};
                    prem <= (div_trial >= DIVISOR) ? (div_trial - DIVISOR) : div_trial;
                    cnt  <= cnt + 5'd1;
                end
                S_OUT: begin
                    // Quotient is at most 294 and never exceeds the segment drop.
                    bus.o_adc_value <= ntc_code(idx) - prod[11:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_temp_to_adc.sv
// Bench for temp_to_adc: directed conversions with literal expectations plus
// a cycle-level reference model compared against the outputs every cycle.
module tb_temp_to_adc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    temp_to_adc_if bus ();

    temp_to_adc dut (
        .i_clk_50m (clk),
        .i_rst     (rst),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    localparam int T [22] = '{2853, 2558, 2271, 1997, 1742, 1510, 1302, 1118,
                              958, 820, 701, 599, 513, 439, 377, 325, 280,
                              242, 209, 181, 159, 138};

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int shown    = 0;

    // Expected ADC code straight from the interpolation rule.
    function automatic int model_code(input int v);
        int k;
        int r;
        if (v >= 26880) return 138;
        k = v / 1280;
        r = v % 1280;
        return T[k] - ((T[k] - T[k+1]) * r) / 1280;
    endfunction

    // Edge index (counted from the capture edge) at which DONE is entered.
    function automatic int model_lat(input int v);
        if (v >= 26880) return 1;
        return v / 1280 + 34;
    endfunction

    // Reference model: transaction timing derived from the latency rule.
    int          cyc = 0;
    int          m_done_at;
    int          m_pending;
    logic        m_busy;
    logic        m_done;
    logic [11:0] m_out;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            m_out     <= '0;
            m_done_at <= -10;
            m_pending <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (bus.i_temp_start) begin
                    m_busy    <= 1'b1;
                    m_done_at <= cyc + model_lat(int'(bus.i_temp_value));
                    m_pending <= model_code(int'(bus.i_temp_value));
                end
            end else if (cyc == m_done_at) begin
                m_done <= 1'b1;
                m_out  <= 12'(m_pending);
            end else if (cyc == m_done_at + 1) begin
                m_busy <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            tests += 3;
            if (bus.o_busy !== m_busy) begin
                fails++;
                if (shown < 40) $display("FAIL cyc_busy @%0d: got %b, expected %b", cyc, bus.o_busy, m_busy);
                shown++;
            end
            if (bus.o_adc_done !== m_done) begin
                fails++;
                if (shown < 40) $display("FAIL cyc_done @%0d: got %b, expected %b", cyc, bus.o_adc_done, m_done);
                shown++;
            end
            if (bus.o_adc_value !== m_out) begin
                fails++;
                if (shown < 40) $display("FAIL cyc_value @%0d: got %0d, expected %0d", cyc, bus.o_adc_value, m_out);
                shown++;
            end
            if (bus.o_adc_done === 1'b1) done_cnt++;
        end
    end

    // Issue one start pulse; returns at the first negedge after the capture edge.
    task automatic kick(input logic [15:0] v);
        @(negedge clk);
        bus.i_temp_value = v;
        bus.i_temp_start = 1'b1;
        @(negedge clk);
        bus.i_temp_start = 1'b0;
    endtask

    // k counts negedges since the capture edge; done in cycle after edge D => k = D+1.
    task automatic wait_done(inout int k);
        while (bus.o_adc_done !== 1'b1 && k < 120) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_conv(input string name, input logic [15:0] v,
                            input int exp_val, input int exp_lat);
        int k;
        kick(v);
        k = 1;
        wait_done(k);
        chk({name, "_done"}, int'(bus.o_adc_done === 1'b1), 1);
        chk({name, "_lat"}, k - 1, exp_lat);
        chk({name, "_val"}, int'(bus.o_adc_value), exp_val);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int k;
        int pre;
        int n;
        int got [4];
        int wide;
        logic prev;

        bus.i_temp_value = '0;
        bus.i_temp_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",  int'(bus.o_busy), 0);
        chk("reset_done",  int'(bus.o_adc_done), 0);
        chk("reset_value", int'(bus.o_adc_value), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table points
        run_conv("pt_0c",    16'h0000, 2853, 34);
        run_conv("pt_25c",   16'h1900, 1510, 39);
        run_conv("pt_100c",  16'h6400, 159, 54);
        // Interpolation
        run_conv("ip_2p5c",  16'h0280, 2706, 34);
        run_conv("ip_102p5", 16'h6680, 149, 54);
        // Clamp and its boundary
        run_conv("cl_105c",  16'h6900, 138, 1);
        run_conv("cl_ffff",  16'hFFFF, 138, 1);
        run_conv("cl_68ff",  16'h68FF, 139, 54);

        // Start while busy: second request must be dropped.
        pre = done_cnt;
        kick(16'h0280);
        repeat (9) @(negedge clk);
        bus.i_temp_value = 16'h0000;
        bus.i_temp_start = 1'b1;
        @(negedge clk);
        bus.i_temp_start = 1'b0;
        bus.i_temp_value = 16'hABCD;
        k = 11;
        wait_done(k);
        chk("busy_start_lat", k - 1, 34);
        chk("busy_start_val", int'(bus.o_adc_value), 2706);
        repeat (60) @(negedge clk);
        chk("busy_start_pulses", done_cnt - pre, 1);

        // Back-to-back with start held high, alternating values.
        @(negedge clk);
        bus.i_temp_value = 16'h6900;
        bus.i_temp_start = 1'b1;
        n = 0;
        wide = 0;
        prev = 1'b0;
        for (int c = 0; c < 400 && n < 4; c++) begin
            @(negedge clk);
            if (bus.o_adc_done === 1'b1) begin
                if (prev) wide++;
                got[n] = int'(bus.o_adc_value);
                n++;
                bus.i_temp_value = (n % 2 == 1) ? 16'h1900 : 16'h6900;
                if (n == 4) bus.i_temp_start = 1'b0;
            end
            prev = bus.o_adc_done;
        end
        bus.i_temp_start = 1'b0;
        chk("b2b_count", n, 4);
        chk("b2b_wide",  wide, 0);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("b2b_val%0d", i), got[i], (i % 2 == 0) ? 138 : 1510);
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a conversion aborts it.
        kick(16'h0280);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_busy",  int'(bus.o_busy), 0);
        chk("midrst_done",  int'(bus.o_adc_done), 0);
        chk("midrst_value", int'(bus.o_adc_value), 0);
        rst = 1'b0;
        pre = done_cnt;
        repeat (70) @(negedge clk);
        chk("midrst_no_pulse", done_cnt - pre, 0);
        run_conv("post_rst_25c", 16'h1900, 1510, 39);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
